// File: rtl/pipe_skid_reg_pkg.sv
// pipe_pkg: shared types and constants for the pipeline stage registers.
//   PIPE_EXC_W   - exception-code width (ExcCode[6:2])
//   exc_code_t   - exception-code type
//   PIPE_NOP     - all-zero payload presented as a bubble
//   pipe_state_e - occupancy of a skid stage: EMPTY, ONE (main), FULL (main + skid)
package pipe_pkg;
    localparam int PIPE_EXC_W  = 5;
    localparam int PIPE_DATA_W = 96;
    typedef logic [PIPE_EXC_W-1:0] exc_code_t;
    localparam logic [PIPE_DATA_W-1:0] PIPE_NOP = '0;
    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } pipe_state_e;
endpackage

// File: rtl/pipe_skid_reg_if.sv
// pipe_skid_reg_if: handshake bundle around one pipeline stage register.
//   master: upstream producer / downstream consumer side (drives In*, OutReady, Flush)
//   slave : the stage itself (drives InReady, Out*)
//   Signals: Flush, InValid/InReady/InData/InBD/InExc, OutValid/OutReady/OutData/OutBD/OutExc
interface pipe_skid_reg_if import pipe_pkg::*; #(
    parameter int DATA_W = 96,
    parameter int EXC_W  = PIPE_EXC_W
);
    logic              Flush;
    logic              InValid;
    logic              InReady;
    logic [DATA_W-1:0] InData;
    logic              InBD;
    logic [EXC_W-1:0]  InExc;
    logic              OutValid;
    logic              OutReady;
    logic [DATA_W-1:0] OutData;
    logic              OutBD;
    logic [EXC_W-1:0]  OutExc;

    modport master (
        output Flush, InValid, InData, InBD, InExc, OutReady,
        input  InReady, OutValid, OutData, OutBD, OutExc
    );

    modport slave (
        input  Flush, InValid, InData, InBD, InExc, OutReady,
        output InReady, OutValid, OutData, OutBD, OutExc
    );
endinterface

// File: rtl/pipe_skid_reg_entry.sv
// pipe_entry: one stage entry (valid, data, BD, exc) with load and clear.
//   Clk, Reset      - clock, synchronous active-high reset
//   i_load          - capture i_data/i_bd/i_exc and mark valid
//   i_clr           - return to an all-zero invalid entry (wins over i_load)
//   o_valid/o_data/o_bd/o_exc - stored entry
module pipe_entry import pipe_pkg::*; #(
    parameter int DATA_W = 96,
    parameter int EXC_W  = PIPE_EXC_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              i_load,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_bd,
    input  logic [EXC_W-1:0]  i_exc,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_bd,
    output logic [EXC_W-1:0]  o_exc
);
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_bd;
    logic [EXC_W-1:0]  r_exc;

    always_ff @(posedge Clk) begin
        if (Reset || i_clr) begin
            r_valid <= 1'b0;
            r_data  <= DATA_W'(PIPE_NOP);
            r_bd    <= 1'b0;
            r_exc   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_bd    <= i_bd;
            r_exc   <= i_exc;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_bd    = r_bd;
    assign o_exc   = r_exc;
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: pipeline stage register with valid/ready handshake, 2-entry skid buffer and flush.
//   Clk, Reset - clock, synchronous active-high reset (clears everything, counters included)
//   bus        - pipe_skid_reg_if.slave: Flush, In* (upstream), Out* (downstream head)
//   StallCnt, FlushCnt - saturating statistics, present only with PIPE_REG_STATS_EN defined
// Invalid entries are held as zero, so the outputs read as a NOP bubble whenever OutValid=0.
module pipe_skid_reg import pipe_pkg::*; #(
    parameter int DATA_W = 96,
    parameter int EXC_W  = PIPE_EXC_W,
    parameter int CNT_W  = 16
) (
    input  logic Clk,
    input  logic Reset,
    pipe_skid_reg_if.slave bus
`ifdef PIPE_REG_STATS_EN
    ,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
`endif
);
    pipe_state_e       r_state, w_state_nxt;
    logic              w_push, w_pop;
    logic              w_main_ld, w_main_clr, w_skid_ld, w_skid_clr;
    logic              w_main_v, w_skid_v;
    logic [DATA_W-1:0] w_main_d, w_skid_d, w_src_d;
    logic              w_main_bd, w_skid_bd, w_src_bd;
    logic [EXC_W-1:0]  w_main_e, w_skid_e, w_src_e;

    // InReady depends only on the registered skid valid, never on OutReady.
    assign w_push = bus.InValid && !w_skid_v;
    assign w_pop  = w_main_v && bus.OutReady;

    always_ff @(posedge Clk) begin
        if (Reset || bus.Flush)
            r_state <= EMPTY;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_ld   = 1'b0;
        w_main_clr  = 1'b0;
        w_skid_ld   = 1'b0;
        w_skid_clr  = 1'b0;
        case (r_state)
            EMPTY: if (w_push) begin
                w_state_nxt = ONE;
                w_main_ld   = 1'b1;
            end
            ONE: if (w_pop && w_push) begin
                w_main_ld = 1'b1;
            end else if (w_pop) begin
                w_state_nxt = EMPTY;
                w_main_clr  = 1'b1;
            end else if (w_push) begin
                w_state_nxt = FULL;
                w_skid_ld   = 1'b1;
            end
            FULL: if (w_pop) begin
                w_state_nxt = ONE;
                w_main_ld   = 1'b1;
                w_skid_clr  = 1'b1;
            end
            default: w_state_nxt = EMPTY;
        endcase
        // Clear wins over load inside the entries, so flush needs no load masking.
        if (bus.Flush) begin
            w_state_nxt = EMPTY;
            w_main_clr  = 1'b1;
            w_skid_clr  = 1'b1;
        end
    end

    // Main refills from skid when draining FULL, otherwise straight from upstream.
    assign w_src_d  = (r_state == FULL) ? w_skid_d  : bus.InData;
    assign w_src_bd = (r_state == FULL) ? w_skid_bd : bus.InBD;
    assign w_src_e  = (r_state == FULL) ? w_skid_e  : bus.InExc;

    pipe_entry #(.DATA_W(DATA_W), .EXC_W(EXC_W)) u_main (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_load  (w_main_ld),
        .i_clr   (w_main_clr),
        .i_data  (w_src_d),
        .i_bd    (w_src_bd),
        .i_exc   (w_src_e),
        .o_valid (w_main_v),
        .o_data  (w_main_d),
        .o_bd    (w_main_bd),
        .o_exc   (w_main_e)
    );

    pipe_entry #(.DATA_W(DATA_W), .EXC_W(EXC_W)) u_skid (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_load  (w_skid_ld),
        .i_clr   (w_skid_clr),
        .i_data  (bus.InData),
        .i_bd    (bus.InBD),
        .i_exc   (bus.InExc),
        .o_valid (w_skid_v),
        .o_data  (w_skid_d),
        .o_bd    (w_skid_bd),
        .o_exc   (w_skid_e)
    );

    assign bus.InReady  = !w_skid_v;
    assign bus.OutValid = w_main_v;
    assign bus.OutData  = w_main_d;
    assign bus.OutBD    = w_main_bd;
    assign bus.OutExc   = w_main_e;

`ifdef PIPE_REG_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    // Both counters saturate; only Reset clears them.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_main_v && !bus.OutReady && !bus.Flush && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (bus.Flush && (w_main_v || w_skid_v) && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign StallCnt = r_stall_cnt;
    assign FlushCnt = r_flush_cnt;
`else
    // CNT_W only sizes the statistics counters.
    localparam int unused_cnt_w = CNT_W;
`endif
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: self-checking bench for pipe_skid_reg (queue model + directed literals).
// Build with PIPE_REG_STATS_EN defined to also check StallCnt/FlushCnt.
module tb_pipe_skid_reg;
    localparam int DATA_W = 32;
    localparam int EXC_W  = 5;
    localparam int CNT_W  = 4;

    logic Clk = 1'b0;
    logic Reset;
    logic started = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pipe_skid_reg_if #(.DATA_W(DATA_W), .EXC_W(EXC_W)) bus ();

`ifdef PIPE_REG_STATS_EN
    logic [CNT_W-1:0] StallCnt, FlushCnt;
`endif

    pipe_skid_reg #(.DATA_W(DATA_W), .EXC_W(EXC_W), .CNT_W(CNT_W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .bus      (bus)
`ifdef PIPE_REG_STATS_EN
        ,
        .StallCnt (StallCnt),
        .FlushCnt (FlushCnt)
`endif
    );

    always #5 Clk = ~Clk;

    // Model: a FIFO of at most two entries plus the two statistics counters.
    logic [DATA_W-1:0] mq_d[$];
    logic              mq_bd[$];
    logic [EXC_W-1:0]  mq_e[$];
    logic [CNT_W-1:0]  m_stall = '0;
    logic [CNT_W-1:0]  m_flush = '0;
    logic [DATA_W-1:0] dut_log[$];

    always @(posedge Clk) begin
        int sz;
        sz = mq_d.size();
        if (!Reset && bus.OutValid && bus.OutReady)
            dut_log.push_back(bus.OutData);
        if (Reset) begin
            mq_d.delete(); mq_bd.delete(); mq_e.delete();
            m_stall = '0;
            m_flush = '0;
        end else begin
            if (sz > 0 && !bus.OutReady && !bus.Flush && m_stall != {CNT_W{1'b1}})
                m_stall = m_stall + 1'b1;
            if (bus.Flush && sz > 0 && m_flush != {CNT_W{1'b1}})
                m_flush = m_flush + 1'b1;
            if (bus.Flush) begin
                mq_d.delete(); mq_bd.delete(); mq_e.delete();
            end else begin
                if (sz > 0 && bus.OutReady) begin
                    void'(mq_d.pop_front()); void'(mq_bd.pop_front()); void'(mq_e.pop_front());
                end
                if (bus.InValid && sz < 2) begin
                    mq_d.push_back(bus.InData); mq_bd.push_back(bus.InBD); mq_e.push_back(bus.InExc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (started) begin
            chk("m_valid", 64'(bus.OutValid), 64'(mq_d.size() > 0));
            chk("m_ready", 64'(bus.InReady), 64'(mq_d.size() < 2));
            chk("m_data", 64'(bus.OutData), 64'(mq_d.size() > 0 ? mq_d[0] : '0));
            chk("m_bd", 64'(bus.OutBD), 64'(mq_d.size() > 0 ? mq_bd[0] : 1'b0));
            chk("m_exc", 64'(bus.OutExc), 64'(mq_d.size() > 0 ? mq_e[0] : '0));
`ifdef PIPE_REG_STATS_EN
            chk("m_stall", 64'(StallCnt), 64'(m_stall));
            chk("m_flush", 64'(FlushCnt), 64'(m_flush));
`endif
        end
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic ordy,
                         input logic fl, input logic bd = 1'b0, input logic [EXC_W-1:0] e = '0);
        bus.InValid  = v;
        bus.InData   = d;
        bus.InBD     = bd;
        bus.InExc    = e;
        bus.OutReady = ordy;
        bus.Flush    = fl;
    endtask

    initial begin
        Reset = 1'b1;
        repeat (2) begin
            drive(1'($urandom_range(1)), DATA_W'($urandom), 1'($urandom_range(1)),
                  1'($urandom_range(1)), 1'($urandom_range(1)), EXC_W'($urandom_range(31)));
            tick;
            started = 1'b1;
        end
        chk("rst_valid", 64'(bus.OutValid), 64'd0);
        chk("rst_data", 64'(bus.OutData), 64'd0);
        chk("rst_ready", 64'(bus.InReady), 64'd1);
`ifdef PIPE_REG_STATS_EN
        chk("rst_stall", 64'(StallCnt), 64'd0);
        chk("rst_flush", 64'(FlushCnt), 64'd0);
`endif
        Reset = 1'b0;

        dut_log.delete();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DATA_W'(i), 1'b1, 1'b0);
            tick;
            chk("stream_valid", 64'(bus.OutValid), 64'd1);
            chk("stream_data", 64'(bus.OutData), 64'(i));
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick;
        chk("stream_end_valid", 64'(bus.OutValid), 64'd0);
        chk("stream_count", 64'(dut_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < dut_log.size(); i++)
            chk("stream_order", 64'(dut_log[i]), 64'(i + 1));

        dut_log.delete();
        drive(1'b1, 'hA, 1'b0, 1'b0);
        tick;
        chk("skid_a_data", 64'(bus.OutData), 64'hA);
        chk("skid_a_ready", 64'(bus.InReady), 64'd1);
        drive(1'b1, 'hB, 1'b0, 1'b0);
        tick;
        chk("skid_full_ready", 64'(bus.InReady), 64'd0);
        chk("skid_full_data", 64'(bus.OutData), 64'hA);
        drive(1'b1, 'hC, 1'b0, 1'b0);
        repeat (2) begin
            tick;
            chk("skid_hold_data", 64'(bus.OutData), 64'hA);
            chk("skid_hold_ready", 64'(bus.InReady), 64'd0);
        end
`ifdef PIPE_REG_STATS_EN
        chk("skid_stall_cnt", 64'(StallCnt), 64'd3);
`endif
        drive(1'b0, '0, 1'b1, 1'b0);
        tick;
        chk("skid_pop_a_ready", 64'(bus.InReady), 64'd1);
        chk("skid_pop_a_data", 64'(bus.OutData), 64'hB);
        tick;
        chk("skid_drain_valid", 64'(bus.OutValid), 64'd0);
        chk("skid_log_size", 64'(dut_log.size()), 64'd2);
        if (dut_log.size() == 2) begin
            chk("skid_log_0", 64'(dut_log[0]), 64'hA);
            chk("skid_log_1", 64'(dut_log[1]), 64'hB);
        end

        dut_log.delete();
        drive(1'b1, 'hA, 1'b0, 1'b0);
        tick;
        drive(1'b1, 'hB, 1'b0, 1'b0);
        tick;
        chk("flush_pre_ready", 64'(bus.InReady), 64'd0);
        drive(1'b1, 'hC, 1'b0, 1'b1);
        tick;
        chk("flush_valid", 64'(bus.OutValid), 64'd0);
        chk("flush_data", 64'(bus.OutData), 64'd0);
        chk("flush_ready", 64'(bus.InReady), 64'd1);
`ifdef PIPE_REG_STATS_EN
        chk("flush_cnt", 64'(FlushCnt), 64'd1);
`endif
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (2) tick;
        chk("flush_no_c", 64'(dut_log.size()), 64'd0);

        drive(1'b1, 'h55, 1'b1, 1'b0, 1'b1, 5'd12);
        tick;
        chk("bd_data", 64'(bus.OutData), 64'h55);
        chk("bd_flag", 64'(bus.OutBD), 64'd1);
        chk("bd_exc", 64'(bus.OutExc), 64'd12);
        drive(1'b0, '0, 1'b1, 1'b0);
        tick;
        chk("bubble_valid", 64'(bus.OutValid), 64'd0);
        chk("bubble_data", 64'(bus.OutData), 64'd0);
        chk("bubble_bd", 64'(bus.OutBD), 64'd0);
        chk("bubble_exc", 64'(bus.OutExc), 64'd0);

        drive(1'b1, 'h1, 1'b0, 1'b0);
        tick;
        drive(1'b1, 'h2, 1'b0, 1'b0);
        tick;
        Reset = 1'b1;
        drive(1'b1, 'h3, 1'b0, 1'b0);
        tick;
        Reset = 1'b0;
        chk("midrst_valid", 64'(bus.OutValid), 64'd0);
        chk("midrst_ready", 64'(bus.InReady), 64'd1);
`ifdef PIPE_REG_STATS_EN
        chk("midrst_stall", 64'(StallCnt), 64'd0);
`endif

        drive(1'b1, 'h77, 1'b0, 1'b0);
        tick;
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat ((1 << CNT_W) + 5) tick;
        chk("sat_data", 64'(bus.OutData), 64'h77);
`ifdef PIPE_REG_STATS_EN
        chk("sat_stall", 64'(StallCnt), 64'hF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline-stage register with a valid/ready handshake, a two-entry skid buffer and synchronous flush. It replaces the fixed-format enable/flush stage registers between CPU pipeline stages (F/D, D/E, E/M, M/W). The payload width, exception-code width and branch-delay flag are carried generically. Stalls propagate upstream one cycle late without a combinational ready path, and bubbles always appear as all-zero payloads (NOP).

## Interface
Parameters:
- DATA_W, default 96: payload width (for example Instr, PC4 and PC concatenated).
- EXC_W, default 5: exception-code width (ExcCode[6:2]).
- CNT_W, default 16: statistics counter width. Used only with PIPE_REG_STATS_EN.

Ports:
- Clk, input, 1: clock. All state is updated on the rising edge.
- Reset, input, 1: synchronous, active-high. Clears all state.
- Flush, input, 1: synchronous. Discards every held entry and any same-cycle input.
- InValid, input, 1: upstream entry present.
- InReady, output, 1: the stage can accept an entry this cycle.
- InData, input, DATA_W: upstream payload.
- InBD, input, 1: upstream branch-delay flag.
- InExc, input, EXC_W: upstream exception code.
- OutValid, output, 1: the head entry is valid.
- OutReady, input, 1: downstream accepts the head this cycle.
- OutData, output, DATA_W: head payload.
- OutBD, output, 1: head branch-delay flag.
- OutExc, output, EXC_W: head exception code.
- StallCnt, output, CNT_W: stall-cycle counter. Present only with PIPE_REG_STATS_EN.
- FlushCnt, output, CNT_W: flush-event counter. Present only with PIPE_REG_STATS_EN.

## Operation
- Storage is two entries, main (head) and skid. Each entry holds valid, data, BD and exc.
- A push happens when InValid && InReady. A pop happens when OutValid && OutReady.
- InReady = !skid.valid. It is driven from a register, so there is no combinational path from OutReady to InReady.
- The outputs are the main entry. Whenever OutValid=0, OutData, OutBD and OutExc read 0 (NOP bubble).
- States are EMPTY (no valid entries), ONE (main valid) and FULL (main and skid valid).
- Transitions from EMPTY:
  - push goes to ONE.
  - no push stays EMPTY.
- Transitions from ONE:
  - pop with push: main takes the input, state stays ONE.
  - pop without push: main is cleared to zero, state goes to EMPTY.
  - push without pop: the input goes to skid, state goes to FULL.
  - neither: hold.
- Transitions from FULL (InReady=0, so a push cannot occur):
  - pop: skid moves to main, skid is cleared, state goes to ONE.
  - no pop: hold.
- Ordering is strictly FIFO. Entries are never duplicated or dropped, except by Flush or Reset.
- Flush=1 takes priority over everything. Both entries are cleared to zero and any same-cycle push is discarded. The next state is EMPTY.
  - A same-cycle pop is still considered delivered: downstream sampled the head in that cycle.
- Reset has the same effect as Flush and takes priority over it.
- Exception codes and BD travel untouched with their payload. The block never generates exceptions.

## Timing
- Reset values: OutValid=0, OutData=0, OutBD=0, OutExc=0, InReady=1, and both counters 0.
- Latency is 1 cycle: a push at edge N is visible on the outputs after edge N.
- Throughput is 1 entry per cycle while OutReady stays high.
- After OutReady drops with the stage in ONE, exactly one further entry is absorbed (into skid). InReady falls after the next edge.
- After OutReady rises again with the stage in FULL, InReady=1 the cycle after the first pop.
- A mid-operation Reset or Flush in any state produces EMPTY after the edge. InReady=1 from the following cycle.

## Configuration
- Macro: PIPE_REG_STATS_EN.
- When defined:
  - StallCnt increments in each cycle where OutValid && !OutReady && !Flush.
  - FlushCnt increments in each cycle where Flush=1 and at least one entry is valid.
  - Both counters saturate at 2^CNT_W-1 and are cleared by Reset only.
- When undefined: the counter ports and their logic are absent, and the datapath behaviour is identical.

## Structure
- Shared package pipe_pkg:
  - PIPE_EXC_W = 5.
  - The ExcCode typedef.
  - The NOP payload constant (all zero).
  - The pipe state enum: EMPTY, ONE, FULL.
- Sub-module pipe_entry: one entry register (valid, data, BD, exc) with load and clear controls. It is instantiated twice, for main and skid.

## Test plan
- Reset held for 2 cycles with random inputs -> OutValid=0, OutData=0, InReady=1, counters 0.
- Streaming 0x1..0x8 with OutReady=1 -> each value appears 1 cycle after its push, in order, with no gaps.
- Push A; drop OutReady; push B; hold for 3 cycles -> InReady=0 from the cycle after B, OutData=A steady, StallCnt=3 with the macro. Raise OutReady -> A then B are delivered, and InReady=1 after A pops.
- FULL state (A, B) with Flush=1 and a simultaneous push of C -> next cycle OutValid=0, OutData=0, InReady=1, C is never output, FlushCnt=1.
- Entry with InBD=1 and InExc=5'd12 -> OutBD=1 and OutExc=12 on the same cycle as its data. The next bubble reads all zeros.
- Holding OutValid=1 with OutReady=0 for 2^CNT_W+5 cycles -> StallCnt saturates at its maximum value and does not wrap.
